// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and widths for the register-file writeback port arbiter.
//   XLEN       : register / writeback data width
//   RF_ADDR_W  : register-file address width
//   wb_req_t   : one register-file write request {addr, data}
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/wb_noc_fifo.sv
// ---------------------------------------------------------------------------
// wb_noc_fifo
// Small circular FIFO holding NoC load-return writes until the register-file
// port is free. Besides the head it exposes a per-entry valid/address vector
// so the arbiter can detect a pipeline write that would overtake a queued
// NoC write to the same register.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (flushes the queue)
//   push_i        : enqueue push_req_i (caller guarantees not full)
//   push_req_i    : {addr, data} to enqueue
//   pop_i         : dequeue head (caller guarantees not empty)
//   head_o        : oldest queued entry
//   empty_o       : no entries queued
//   full_o        : DEPTH entries queued
//   cnt_o         : number of queued entries
//   ent_vld_o     : per-slot "holds a queued entry"
//   ent_addr_o    : per-slot destination register
// ---------------------------------------------------------------------------
module wb_noc_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push_i,
    input  wb_req_t                              push_req_i,
    input  logic                                 pop_i,
    output wb_req_t                              head_o,
    output logic                                 empty_o,
    output logic                                 full_o,
    output logic [$clog2(DEPTH):0]               cnt_o,
    output logic [DEPTH-1:0]                     ent_vld_o,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0]      ent_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally; the extra count bit
    // separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs          = PTR_W'(i) - rd_ptr_q;
            ent_vld_o[i]  = ({1'b0, offs} < cnt_q);
            ent_addr_o[i] = mem_q[i].addr;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the MEM/WB writeback
// and NoC load returns. NoC returns wait in wb_noc_fifo; the pipeline has
// priority, except that a pipeline write to a register with a queued NoC
// write stalls the pipeline and drains the head first, preserving order.
// Optional macro WB_ARB_AGE_EN: an age counter forces a FIFO pop (with
// stall_o) once the head has waited MAX_WAIT cycles; without it the pipeline
// has strict priority and no counter exists.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   pipe_we_i/addr_i/data_i : MEM/WB writeback request (addr 0 = no request)
//   noc_valid_i/addr_i/data_i, noc_ready_o : NoC return handshake
//   rf_we_o/addr_o/data_o   : registered register-file write port
//   stall_o                 : combinational; MEM/WB holds pipe_* next cycle
//   fifo_cnt_o              : queued NoC entries
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pipe_we_i,
    input  logic [RF_ADDR_W-1:0]    pipe_addr_i,
    input  logic [XLEN-1:0]         pipe_data_i,
    input  logic                    noc_valid_i,
    output logic                    noc_ready_o,
    input  logic [RF_ADDR_W-1:0]    noc_addr_i,
    input  logic [XLEN-1:0]         noc_data_i,
    output logic                    rf_we_o,
    output logic [RF_ADDR_W-1:0]    rf_addr_o,
    output logic [XLEN-1:0]         rf_data_o,
    output logic                    stall_o,
    output logic [$clog2(DEPTH):0]  fifo_cnt_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_cfg
        $error("wb_port_arbiter: DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
    end

    logic                             full, empty, push, pop;
    wb_req_t                          head, push_req;
    logic [DEPTH-1:0]                 ent_vld;
    logic [DEPTH-1:0][RF_ADDR_W-1:0]  ent_addr;
    logic                             pipe_req, conflict, force_pop;

    logic                  rf_we_d,   rf_we_q;
    logic [RF_ADDR_W-1:0]  rf_addr_d, rf_addr_q;
    logic [XLEN-1:0]       rf_data_d, rf_data_q;

    // Returns to x0 are acknowledged but dropped: they would never reach the regfile.
    assign noc_ready_o = !full;
    assign push        = noc_valid_i && !full && (noc_addr_i != '0);
    assign push_req    = '{addr: noc_addr_i, data: noc_data_i};
    assign pipe_req    = pipe_we_i && (pipe_addr_i != '0);

    wb_noc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_req_i (push_req),
        .pop_i      (pop),
        .head_o     (head),
        .empty_o    (empty),
        .full_o     (full),
        .cnt_o      (fifo_cnt_o),
        .ent_vld_o  (ent_vld),
        .ent_addr_o (ent_addr)
    );

    // Only already-stored entries count; a same-cycle push cannot conflict.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == pipe_addr_i)) conflict = 1'b1;
        end
        conflict = conflict && pipe_req;
    end

`ifdef WB_ARB_AGE_EN
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    logic [AGE_W-1:0] age_q, age_d;

    assign force_pop = !empty && (age_q == AGE_W'(MAX_WAIT));
    // Counts cycles the head sits unserved; any pop or an empty queue restarts it.
    assign age_d     = (empty || pop) ? '0 : age_q + AGE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) age_q <= '0;
        else       age_q <= age_d;
    end
`else
    assign force_pop = 1'b0;
`endif

    assign stall_o = conflict || force_pop;

    always_comb begin
        pop       = 1'b0;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (conflict || force_pop) begin
            pop       = 1'b1;
            rf_we_d   = 1'b1;
            rf_addr_d = head.addr;
            rf_data_d = head.data;
        end else if (pipe_req) begin
            rf_we_d   = 1'b1;
            rf_addr_d = pipe_addr_i;
            rf_data_d = pipe_data_i;
        end else if (!empty) begin
            pop       = 1'b1;
            rf_we_d   = 1'b1;
            rf_addr_d = head.addr;
            rf_data_d = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we_o   = rf_we_q;
    assign rf_addr_o = rf_addr_q;
    assign rf_data_o = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        noc_valid;
    logic        noc_ready;
    logic [4:0]  noc_addr;
    logic [31:0] noc_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall;
    logic [2:0]  fifo_cnt;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we_i   (pipe_we),
        .pipe_addr_i (pipe_addr),
        .pipe_data_i (pipe_data),
        .noc_valid_i (noc_valid),
        .noc_ready_o (noc_ready),
        .noc_addr_i  (noc_addr),
        .noc_data_i  (noc_data),
        .rf_we_o     (rf_we),
        .rf_addr_o   (rf_addr),
        .rf_data_o   (rf_data),
        .stall_o     (stall),
        .fifo_cnt_o  (fifo_cnt)
    );

    // Reference model: a queue of pending NoC writes plus the expected port outputs.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_age;
    logic        last_stall;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we = we; pipe_addr = a; pipe_data = d;
    endtask

    task automatic set_noc(input logic v, input logic [4:0] a, input logic [31:0] d);
        noc_valid = v; noc_addr = a; noc_data = d;
    endtask

    // One clock with the inputs currently driven: checks combinational outputs,
    // advances the model, then checks the registered port after the edge.
    task automatic step();
        bit   preq, conflict, force_pop, exp_stall, pop, push, nwe;
        ent_t w;
        #1;
        preq     = pipe_we && (pipe_addr != 5'd0);
        conflict = 1'b0;
        if (preq) foreach (q[i]) if (q[i].a == pipe_addr) conflict = 1'b1;
        force_pop = 1'b0;
`ifdef WB_ARB_AGE_EN
        force_pop = (q.size() != 0) && (m_age == MAX_WAIT);
`endif
        exp_stall = conflict || force_pop;
        check("stall_o", 64'(stall), 64'(exp_stall));
        check("noc_ready_o", 64'(noc_ready), 64'(q.size() != DEPTH));
        check("fifo_cnt_o", 64'(fifo_cnt), 64'(q.size()));
        last_stall = exp_stall;

        pop = 1'b0; nwe = 1'b0; w = '0;
        if (exp_stall) begin
            pop = 1'b1; nwe = 1'b1; w = q[0];
        end else if (preq) begin
            nwe = 1'b1; w = '{a: pipe_addr, d: pipe_data};
        end else if (q.size() != 0) begin
            pop = 1'b1; nwe = 1'b1; w = q[0];
        end
        if (q.size() == 0 || pop) m_age = 0;
        else                      m_age++;
        push = noc_valid && (q.size() != DEPTH) && (noc_addr != 5'd0);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back('{a: noc_addr, d: noc_data});
        m_we = nwe;
        if (nwe) begin
            m_addr = w.a;
            m_data = w.d;
        end

        @(posedge clk); #1;
        check("rf_we_o", 64'(rf_we), 64'(m_we));
        check("rf_addr_o", 64'(rf_addr), 64'(m_addr));
        check("rf_data_o", 64'(rf_data), 64'(m_data));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_noc(1'b0, 5'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        q.delete();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_age = 0; last_stall = 1'b0;
        check("rst rf_we_o", 64'(rf_we), 64'd0);
        check("rst rf_addr_o", 64'(rf_addr), 64'd0);
        check("rst rf_data_o", 64'(rf_data), 64'd0);
        check("rst stall_o", 64'(stall), 64'd0);
        check("rst noc_ready_o", 64'(noc_ready), 64'd1);
        check("rst fifo_cnt_o", 64'(fifo_cnt), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset
        do_reset();

        // Plain pipeline write
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("t2 rf_we", 64'(rf_we), 64'd1);
        check("t2 rf_addr", 64'(rf_addr), 64'd5);
        check("t2 rf_data", 64'(rf_data), 64'hDEADBEEF);

        // Single NoC return: queued, then written two cycles after accept
        set_pipe(1'b0, 5'd0, 32'd0);
        set_noc(1'b1, 5'd7, 32'h00001234);
        step();
        check("t3 cnt after accept", 64'(fifo_cnt), 64'd1);
        check("t3 no early write", 64'(rf_we), 64'd0);
        set_noc(1'b0, 5'd0, 32'd0);
        step();
        check("t3 rf_we", 64'(rf_we), 64'd1);
        check("t3 rf_addr", 64'(rf_addr), 64'd7);
        check("t3 rf_data", 64'(rf_data), 64'h1234);
        check("t3 cnt drained", 64'(fifo_cnt), 64'd0);

        // Pipeline stream x1..x6 while NoC fills the FIFO with x10..x13
        for (int i = 1; i <= 6; i++) begin
            set_pipe(1'b1, 5'(i), 32'h100 + 32'(i));
            if (i <= 4) set_noc(1'b1, 5'(9 + i), 32'h200 + 32'(i));
            else        set_noc(1'b0, 5'd0, 32'd0);
            step();
            check("t4 pipe first", 64'(rf_addr), 64'(i));
            if (i == 4) check("t4 ready low when full", 64'(noc_ready), 64'd0);
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4 drain addr", 64'(rf_addr), 64'(10 + i));
            check("t4 drain data", 64'(rf_data), 64'(32'h201 + 32'(i)));
        end

        // Write-after-write hazard: queued x9 must land before the pipeline's x9
        set_noc(1'b1, 5'd9, 32'h11);
        step();
        set_noc(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd9, 32'hAAAA);
        #1;
        check("t5 stall", 64'(stall), 64'd1);
        step();
        check("t5 first data", 64'(rf_data), 64'h11);
        check("t5 stall cleared", 64'(stall), 64'd0);
        step();
        check("t5 second data", 64'(rf_data), 64'hAAAA);

        // x0 from both sources never reaches the regfile
        set_pipe(1'b1, 5'd0, 32'hFFFF);
        set_noc(1'b1, 5'd0, 32'hEEEE);
        step();
        check("t6 no rf_we", 64'(rf_we), 64'd0);
        check("t6 nothing queued", 64'(fifo_cnt), 64'd0);
        set_noc(1'b0, 5'd0, 32'd0);

`ifdef WB_ARB_AGE_EN
        // Starvation limit: continuous pipe writes with one queued entry
        set_noc(1'b1, 5'd20, 32'h5A5A);
        set_pipe(1'b1, 5'd1, 32'h1);
        step();
        set_noc(1'b0, 5'd0, 32'd0);
        for (int c = 1; c <= 9; c++) begin
            set_pipe(1'b1, 5'd1 + 5'(c % 3), 32'(c));
            #1;
            check("age stall timing", 64'(stall), 64'(c == 9));
            step();
        end
        check("age forced pop addr", 64'(rf_addr), 64'd20);
`endif

        // Mid-operation reset drops queued entries and the pending write
        set_pipe(1'b1, 5'd3, 32'h33);
        set_noc(1'b1, 5'd4, 32'h44);
        step();
        step();
        do_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) set_pipe(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 12)), $urandom);
            set_noc(($urandom_range(0, 9) < 5), 5'($urandom_range(0, 12)), $urandom);
            step();
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        set_noc(1'b0, 5'd0, 32'd0);
        for (int n = 0; n < DEPTH + 2; n++) step();
        check("final empty", 64'(fifo_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
